// File: rtl/train_sequencer_if.sv
// train_sequencer_if: forward/backward layer-number channels with their completion pulses
interface train_sequencer_if #(parameter int LAYER_ADDR_WIDTH = 2);
   logic [LAYER_ADDR_WIDTH-1:0] fw_layer_number;
   logic fw_layer_number_valid;
   logic fw_layer_number_ready;
   logic fw_done;
   logic [LAYER_ADDR_WIDTH-1:0] bw_layer_number;
   logic bw_layer_number_valid;
   logic bw_layer_number_ready;
   logic bw_done;
   modport master (
      output fw_layer_number, fw_layer_number_valid, bw_layer_number, bw_layer_number_valid,
      input  fw_layer_number_ready, fw_done, bw_layer_number_ready, bw_done
   );
   modport slave (
      input  fw_layer_number, fw_layer_number_valid, bw_layer_number, bw_layer_number_valid,
      output fw_layer_number_ready, fw_done, bw_layer_number_ready, bw_done
   );
endinterface

// File: rtl/train_sequencer.sv
// train_sequencer: issues forward then backward layer numbers per sample over all epochs
module train_sequencer #(
   parameter int LAYER_ADDR_WIDTH = 2,
   parameter int LAYER_MAX = 2,
   parameter int SAMPLE_WIDTH = 10,
   parameter int EPOCH_WIDTH = 8,
   parameter int TIMEOUT_WIDTH = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic [SAMPLE_WIDTH-1:0] num_samples,
   input  logic [EPOCH_WIDTH-1:0] num_epochs,
   train_sequencer_if.master lyr,
   output logic busy,
   output logic done,
   output logic error,
   output logic [SAMPLE_WIDTH-1:0] sample_index,
   output logic [EPOCH_WIDTH-1:0] epoch_index
);
   typedef enum logic [2:0] {IDLE, FW_ISSUE, FW_WAIT, BW_ISSUE, BW_WAIT, ADVANCE} state_t;
   localparam logic [LAYER_ADDR_WIDTH-1:0] L_LAST = LAYER_ADDR_WIDTH'(LAYER_MAX);
   localparam logic [LAYER_ADDR_WIDTH-1:0] L_BW = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);
   localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
   state_t state, state_n;
   logic [LAYER_ADDR_WIDTH-1:0] layer, layer_n;
   logic [SAMPLE_WIDTH-1:0] samples, samples_n, sample_n;
   logic [EPOCH_WIDTH-1:0] epochs, epochs_n, epoch_n;
   logic [TIMEOUT_WIDTH-1:0] wd, wd_n;
   logic error_n, zero_done, zero_done_n, last_sample, last_epoch, finish, timeout;
   assign last_sample = sample_index + SAMPLE_WIDTH'(1) == samples;
   assign last_epoch = epoch_index + EPOCH_WIDTH'(1) == epochs;
   assign finish = state == ADVANCE && last_sample && last_epoch;
   assign timeout = TIMEOUT_CYCLES != 0 && wd == WD_LAST;
   assign lyr.fw_layer_number_valid = state == FW_ISSUE;
   assign lyr.bw_layer_number_valid = state == BW_ISSUE;
   assign lyr.fw_layer_number = state == FW_ISSUE ? layer : '0;
   assign lyr.bw_layer_number = state == BW_ISSUE ? layer : '0;
   assign busy = state != IDLE && !finish;
   assign done = zero_done || finish;
   always_comb begin
      state_n = state;
      layer_n = layer;
      samples_n = samples;
      epochs_n = epochs;
      sample_n = sample_index;
      epoch_n = epoch_index;
      wd_n = wd;
      error_n = error;
      zero_done_n = 1'b0;
      case (state)
         IDLE: if (start) begin
            samples_n = num_samples;
            epochs_n = num_epochs;
            error_n = 1'b0;
            layer_n = '0;
            sample_n = '0;
            epoch_n = '0;
            zero_done_n = num_samples == '0 || num_epochs == '0;
            state_n = zero_done_n ? IDLE : FW_ISSUE;
         end
         FW_ISSUE: if (lyr.fw_layer_number_ready) begin
            wd_n = '0;
            state_n = FW_WAIT;
         end
         FW_WAIT: if (lyr.fw_done) begin
            layer_n = layer == L_LAST ? L_BW : layer + LAYER_ADDR_WIDTH'(1);
            state_n = layer == L_LAST ? BW_ISSUE : FW_ISSUE;
         end else if (timeout) begin
            error_n = 1'b1;
            state_n = IDLE;
         end else wd_n = wd + TIMEOUT_WIDTH'(1);
         BW_ISSUE: if (lyr.bw_layer_number_ready) begin
            wd_n = '0;
            state_n = BW_WAIT;
         end
         BW_WAIT: if (lyr.bw_done) begin
            layer_n = layer == '0 ? layer : layer - LAYER_ADDR_WIDTH'(1);
            state_n = layer == '0 ? ADVANCE : BW_ISSUE;
         end else if (timeout) begin
            error_n = 1'b1;
            state_n = IDLE;
         end else wd_n = wd + TIMEOUT_WIDTH'(1);
         ADVANCE: if (finish) state_n = IDLE;
         else begin
            // indices stay put on the final sample so they report where training ended
            sample_n = last_sample ? '0 : sample_index + SAMPLE_WIDTH'(1);
            epoch_n = last_sample ? epoch_index + EPOCH_WIDTH'(1) : epoch_index;
            layer_n = '0;
            state_n = FW_ISSUE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         layer <= '0;
         samples <= '0;
         epochs <= '0;
         sample_index <= '0;
         epoch_index <= '0;
         wd <= '0;
         error <= 1'b0;
         zero_done <= 1'b0;
      end else begin
         state <= state_n;
         layer <= layer_n;
         samples <= samples_n;
         epochs <= epochs_n;
         sample_index <= sample_n;
         epoch_index <= epoch_n;
         wd <= wd_n;
         error <= error_n;
         zero_done <= zero_done_n;
      end
   end
endmodule

// File: tb/tb_train_sequencer.sv
// tb_train_sequencer: table-driven runs plus hand-written stall, timeout and reset sequences
module tb_train_sequencer;
   localparam int SW = 10;
   localparam int EW = 8;
   logic clk, rst, start, busy, done, error;
   logic [SW-1:0] num_samples, sample_index;
   logic [EW-1:0] num_epochs, epoch_index;
   train_sequencer_if #(.LAYER_ADDR_WIDTH(2)) lyr();
   train_sequencer #(
      .LAYER_ADDR_WIDTH(2), .LAYER_MAX(2), .SAMPLE_WIDTH(SW), .EPOCH_WIDTH(EW),
      .TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .num_epochs(num_epochs),
      .lyr(lyr.master), .busy(busy), .done(done), .error(error),
      .sample_index(sample_index), .epoch_index(epoch_index)
   );
   typedef struct {
      int ns;
      int ne;
      bit mid;
      int exp_fw;
      int exp_bw;
      int exp_lat;
   } vec_t;
   vec_t tbl[6];
   int n_cmp = 0, n_bad = 0;
   int fw_log[$], bw_log[$], si_log[$], ei_log[$];
   int fw_cd = 0, bw_cd = 0, bw_hold = -1, done_cnt = 0, valid_cyc = 0, overlap = 0;
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   // splitter model: accepts per ready, pulses done 3 cycles after each handshake
   initial begin
      lyr.fw_done = 0;
      lyr.bw_done = 0;
      forever begin
         @(negedge clk);
         lyr.fw_done = 0;
         lyr.bw_done = 0;
         if (!rst) begin
            fw_cd = 0;
            bw_cd = 0;
         end else begin
            if (fw_cd > 0) begin
               fw_cd--;
               if (fw_cd == 0) lyr.fw_done = 1;
            end
            if (bw_cd > 0) begin
               bw_cd--;
               if (bw_cd == 0) lyr.bw_done = 1;
            end
            if (lyr.fw_layer_number_valid && lyr.bw_layer_number_valid) overlap++;
            if (lyr.fw_layer_number_valid || lyr.bw_layer_number_valid) valid_cyc++;
            if (lyr.fw_layer_number_valid && lyr.fw_layer_number_ready) begin
               fw_log.push_back(int'(lyr.fw_layer_number));
               si_log.push_back(int'(sample_index));
               ei_log.push_back(int'(epoch_index));
               fw_cd = 3;
            end
            if (lyr.bw_layer_number_valid && lyr.bw_layer_number_ready) begin
               bw_log.push_back(int'(lyr.bw_layer_number));
               if (int'(lyr.bw_layer_number) != bw_hold) bw_cd = 3;
            end
            if (done) done_cnt++;
         end
      end
   end
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic kick(input int ns, input int ne);
      @(posedge clk);
      #1;
      fw_log.delete();
      bw_log.delete();
      si_log.delete();
      ei_log.delete();
      done_cnt = 0;
      valid_cyc = 0;
      num_samples = SW'(ns);
      num_epochs = EW'(ne);
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
   endtask
   task automatic run(input int ns, input int ne, input bit mid, output int lat, output int busy_cnt);
      kick(ns, ne);
      lat = -1;
      busy_cnt = 0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (mid && c == 10) begin
            start = 1;
            num_samples = SW'(7);
            num_epochs = EW'(7);
         end
         if (mid && c == 11) start = 0;
         if (busy) busy_cnt++;
         if (done) begin
            lat = c;
            break;
         end
      end
      repeat (3) @(negedge clk);
   endtask
   initial begin
      int lat, bc, errs, v;
      tbl[0] = '{1, 1, 0, 3, 2, 21};
      tbl[1] = '{3, 2, 0, 18, 12, 126};
      tbl[2] = '{2, 1, 1, 6, 4, 42};
      tbl[3] = '{0, 5, 0, 0, 0, 1};
      tbl[4] = '{4, 0, 0, 0, 0, 1};
      tbl[5] = '{1, 3, 0, 9, 6, 63};
      rst = 0;
      start = 0;
      num_samples = '0;
      num_epochs = '0;
      lyr.fw_layer_number_ready = 1;
      lyr.bw_layer_number_ready = 1;
      #12;
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset error", int'(error), 0);
      chk("reset fw valid", int'(lyr.fw_layer_number_valid), 0);
      chk("reset bw valid", int'(lyr.bw_layer_number_valid), 0);
      chk("reset indices", int'(sample_index) + int'(epoch_index), 0);
      @(posedge clk);
      #1;
      rst = 1;
      for (int i = 0; i < 6; i++) begin
         run(tbl[i].ns, tbl[i].ne, tbl[i].mid, lat, bc);
         chk($sformatf("v%0d done latency", i), lat, tbl[i].exp_lat);
         chk($sformatf("v%0d done pulses", i), done_cnt, 1);
         chk($sformatf("v%0d busy cycles", i), bc, tbl[i].exp_lat - 1);
         chk($sformatf("v%0d fw transfers", i), fw_log.size(), tbl[i].exp_fw);
         chk($sformatf("v%0d bw transfers", i), bw_log.size(), tbl[i].exp_bw);
         chk($sformatf("v%0d valid cycles", i), valid_cyc, tbl[i].exp_fw + tbl[i].exp_bw);
         errs = 0;
         foreach (fw_log[k]) begin
            if (fw_log[k] != k % 3) errs++;
            if (si_log[k] != (k / 3) % tbl[i].ns) errs++;
            if (ei_log[k] != (k / 3) / tbl[i].ns) errs++;
         end
         foreach (bw_log[k]) if (bw_log[k] != 1 - k % 2) errs++;
         chk($sformatf("v%0d order errors", i), errs, 0);
      end
      // forward ready stalls while layer 1 is offered
      kick(1, 1);
      for (int c = 0; c < 50 && fw_log.size() < 1; c++) begin
         @(posedge clk);
         #2;
      end
      lyr.fw_layer_number_ready = 0;
      for (int c = 0; c < 50 && !lyr.fw_layer_number_valid; c++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk($sformatf("stall valid %0d", i), int'(lyr.fw_layer_number_valid), 1);
         chk($sformatf("stall number %0d", i), int'(lyr.fw_layer_number), 1);
      end
      @(posedge clk);
      #2;
      chk("stall no transfer", fw_log.size(), 1);
      lyr.fw_layer_number_ready = 1;
      @(posedge clk);
      #2;
      chk("stall release transfer", fw_log.size(), 2);
      v = fw_log.size() > 1 ? fw_log[1] : -1;
      chk("stall release number", v, 1);
      lat = -1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (done) begin
            lat = c;
            break;
         end
      end
      chk("stall done seen", int'(lat >= 0), 1);
      chk("stall total transfers", fw_log.size() + bw_log.size(), 5);
      // watchdog: bw_done withheld for layer 1
      bw_hold = 1;
      kick(2, 1);
      lat = -1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (error) begin
            lat = c;
            break;
         end
      end
      chk("wd latency", lat, 30);
      chk("wd busy", int'(busy), 0);
      repeat (5) @(negedge clk);
      chk("wd sticky", int'(error), 1);
      chk("wd no done", done_cnt, 0);
      chk("wd bw transfers", bw_log.size(), 1);
      bw_hold = -1;
      run(1, 1, 0, lat, bc);
      chk("restart error", int'(error), 0);
      chk("restart latency", lat, 21);
      v = fw_log.size() > 0 ? fw_log[0] + si_log[0] : -1;
      chk("restart first layer/sample", v, 0);
      // asynchronous reset in FW_WAIT of sample 1
      kick(2, 1);
      for (int c = 0; c < 100 && fw_log.size() < 5; c++) begin
         @(posedge clk);
         #2;
      end
      chk("pre-reset sample index", int'(sample_index), 1);
      #1;
      rst = 0;
      #1;
      chk("async rst busy", int'(busy), 0);
      chk("async rst indices", int'(sample_index) + int'(epoch_index), 0);
      chk("async rst outputs", int'(done) + int'(error) + int'(lyr.fw_layer_number_valid) + int'(lyr.bw_layer_number_valid) + int'(lyr.fw_layer_number) + int'(lyr.bw_layer_number), 0);
      @(posedge clk);
      #1;
      rst = 1;
      run(1, 1, 0, lat, bc);
      chk("post-reset latency", lat, 21);
      v = fw_log.size() > 0 ? fw_log[0] + si_log[0] : -1;
      chk("post-reset first layer/sample", v, 0);
      chk("valid overlap", overlap, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/train_sequencer.md
Name: train_sequencer

Overview:
- Drives the layer-number streams that sequence one training pass of the layer-multiplexed network.
- Per sample: issues forward layer numbers 0..LAYER_MAX into the forward layer splitter, then backward layer numbers LAYER_MAX-1 down to 0 into the backward layer splitter.
- Waits for a completion pulse after each issued layer before issuing the next.
- Repeats for a programmed number of samples and epochs, then reports done.
- Replaces hand-timed layer pulses at top level.

Parameters:
- LAYER_ADDR_WIDTH, 2, width of layer numbers.
- LAYER_MAX, 2, index of last forward layer; backward layers are LAYER_MAX-1..0.
- SAMPLE_WIDTH, 10, width of sample count/index.
- EPOCH_WIDTH, 8, width of epoch count/index.
- TIMEOUT_WIDTH, 16, width of wait watchdog counter.
- TIMEOUT_CYCLES, 1024, wait cycles before error; 0 disables watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  single-cycle request to begin training.
- num_samples  in  SAMPLE_WIDTH  samples per epoch; latched on accepted start.
- num_epochs  in  EPOCH_WIDTH  epochs; latched on accepted start.
- fw_layer_number  out  LAYER_ADDR_WIDTH  forward layer to run.
- fw_layer_number_valid  out  1  forward layer number valid.
- fw_layer_number_ready  in  1  forward splitter accepts.
- fw_done  in  1  pulse: forward layer result written to activation stack.
- bw_layer_number  out  LAYER_ADDR_WIDTH  backward layer to run.
- bw_layer_number_valid  out  1  backward layer number valid.
- bw_layer_number_ready  in  1  backward splitter accepts.
- bw_done  in  1  pulse: weight update for that layer committed.
- busy  out  1  high from accepted start until done or error.
- done  out  1  one-cycle pulse when all epochs complete.
- error  out  1  sticky watchdog flag.
- sample_index  out  SAMPLE_WIDTH  current sample within epoch.
- epoch_index  out  EPOCH_WIDTH  current epoch.

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, counters 0. Takes effect immediately, including mid-transfer; a pending valid drops without handshake.
- States: IDLE, FW_ISSUE, FW_WAIT, BW_ISSUE, BW_WAIT, ADVANCE.
- IDLE: start=1 latches config, clears error, sets busy=1, layer=0, sample/epoch index=0, goes to FW_ISSUE. If num_samples=0 or num_epochs=0, instead pulses done the next cycle with busy=0 and no transfers.
- start while busy is ignored.
- FW_ISSUE: fw_layer_number_valid=1 with fw_layer_number=layer, both stable until ready. A transfer (valid&ready) moves to FW_WAIT.
- FW_WAIT: on fw_done, if layer<LAYER_MAX then layer+1 and FW_ISSUE; else layer=LAYER_MAX-1 and BW_ISSUE.
- BW_ISSUE: bw valid/number, same handshake rules, then BW_WAIT.
- BW_WAIT: on bw_done, if layer>0 then layer-1 and BW_ISSUE; else ADVANCE.
- ADVANCE (one cycle):
  - If sample_index+1<num_samples: sample_index+1.
  - Otherwise sample_index=0 and epoch_index+1.
  - If that was the last sample of the last epoch: done=1 this cycle, busy=0, indices held at final values, then IDLE.
  - Otherwise layer=0 and FW_ISSUE.
- First fw valid is asserted the cycle after start is sampled. Minimum cycles per layer: 1 issue cycle + 1 wait cycle.
- fw_done/bw_done are ignored outside their own WAIT state, including in the handshake cycle.
- At most one valid is high at any time; fw and bw valid are never concurrent.
- Watchdog: counter clears on entering either WAIT state and increments each WAIT cycle without done. On reaching TIMEOUT_CYCLES: error=1, busy=0, state IDLE, no done pulse.
- Index counters compare against latched values; they never wrap past num-1.

Test Plan:
1. LAYER_MAX=2, num_samples=1, num_epochs=1, readies tied 1, each done 3 cycles after its handshake -> fw transfers 0,1,2 then bw transfers 1,0; exactly 5 transfers; single done pulse; busy falls with done.
2. num_samples=3, num_epochs=2 -> 18 fw and 12 bw transfers; sample_index 0,1,2,0,1,2; epoch_index 0 then 1; one done pulse.
3. fw_layer_number_ready low 5 cycles during layer 1 -> valid held high, number stays 1, no state advance; transfer on first ready cycle.
4. num_samples=0 with start -> done pulse next cycle; no valid ever asserted; busy stays 0. Separately, start pulsed while busy -> ignored, sequence unchanged.
5. TIMEOUT_CYCLES=16, bw_done withheld for layer 1 -> error=1 after 16 wait cycles, busy=0, no done. Next start clears error and restarts at fw layer 0, sample 0.
6. rst driven low in FW_WAIT between clock edges -> all outputs 0 without a clock edge. After release, start gives fw_layer_number=0 and sample_index=0.
